// File: rtl/async_mem_pkg.sv
// ---------------------------------------------------------------------------
// async_mem_pkg
// Shared definitions for the asynchronous SRAM-style bus responder:
//   state_t    - responder FSM states
//   BLS_W      - number of byte lanes (byte-lane select width)
//   WORD_OFS   - low address bit of the word index (byte address -> word)
//   MIN_SETUP  - minimum cycles an initiator must hold a read before
//                sampling mem_d (pipeline + FSM + data register, plus margin)
// ---------------------------------------------------------------------------
package async_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int BLS_W     = 4;
  localparam int WORD_OFS  = 2;
  localparam int MIN_SETUP = 5;

endpackage

// File: rtl/async_mem_slave_if.sv
// ---------------------------------------------------------------------------
// async_mem_slave_if
// Control and address half of the asynchronous SRAM-style bus.
//   mem_cs_n  - chip select, active-low
//   mem_oe_n  - output enable, active-low
//   mem_we_n  - write enable, active-low
//   mem_bls_n - byte-lane selects, active-low, bit i = data lane i
//   mem_a     - byte address
// The bidirectional data bus travels as a separate inout port so that its
// tristate resolution stays at module-port level.
// ---------------------------------------------------------------------------
interface async_mem_slave_if
  import async_mem_pkg::*;
#(
  parameter int aw = 32
);

  logic             mem_cs_n;
  logic             mem_oe_n;
  logic             mem_we_n;
  logic [BLS_W-1:0] mem_bls_n;
  logic [aw-1:0]    mem_a;

  modport master (
    output mem_cs_n,
    output mem_oe_n,
    output mem_we_n,
    output mem_bls_n,
    output mem_a
  );

  modport slave (
    input mem_cs_n,
    input mem_oe_n,
    input mem_we_n,
    input mem_bls_n,
    input mem_a
  );

endinterface

// File: rtl/async_mem_sync.sv
// ---------------------------------------------------------------------------
// async_mem_sync
// Three identical flop stages over an arbitrary-width bus. Stage s1 is the
// synchronizer for pins driven from an unrelated timing domain; s2 is the
// value the logic decides on and s3 is the previous decision value, so
// edges are detected as s3 != s2.
//   clk    - sampling clock
//   rst_n  - asynchronous reset, active-low; all stages load RST_VAL
//   i_d    - raw pin vector
//   o_s2   - decision stage
//   o_s3   - previous decision stage
// ---------------------------------------------------------------------------
module async_mem_sync #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_s2,
  output logic [W-1:0] o_s3
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_s2 = r_s2;
  assign o_s3 = r_s3;

endmodule

// File: rtl/async_mem_slave.sv
// ---------------------------------------------------------------------------
// async_mem_slave
// Word-organised scratch memory answering an asynchronous SRAM-style bus.
// All bus pins are oversampled into tb_clk through async_mem_sync; reads
// and byte-lane writes are served by a three-state FSM (IDLE/READ/WRITE).
//   tb_clk     - sole clock
//   tb_rst     - asynchronous reset, active-low
//   bus        - cs_n/oe_n/we_n/bls_n/a (slave modport)
//   mem_d      - data bus, driven only while serving a read, else high-Z
//   wr_count   - committed writes, wraps
//   rd_count   - read accesses served, wraps
//   proto_err  - sticky flag for oe_n and we_n low together under cs_n
// dw must be 32 (four byte lanes).
// ---------------------------------------------------------------------------
module async_mem_slave
  import async_mem_pkg::*;
#(
  parameter int dw     = 32,
  parameter int aw     = 32,
  parameter int mem_aw = 8,
  parameter int cnt_w  = 16
) (
  input  logic              tb_clk,
  input  logic              tb_rst,
  async_mem_slave_if.slave  bus,
  inout  wire  [dw-1:0]     mem_d,
  output logic [cnt_w-1:0]  wr_count,
  output logic [cnt_w-1:0]  rd_count,
  output logic              proto_err
);

  // Pipeline vector layout, MSB first: cs_n, oe_n, we_n, bls_n, a, d.
  // Controls reset to inactive (1), everything else to 0.
  localparam int            SW       = 3 + BLS_W + aw + dw;
  localparam logic [SW-1:0] SYNC_RST = {3'b111, {(SW-3){1'b0}}};

  logic [SW-1:0]     w_pins;
  logic [SW-1:0]     w_s2;
  logic [SW-1:0]     w_s3;

  logic              w_cs2, w_oe2, w_we2;
  logic [BLS_W-1:0]  w_bls2;
  logic [aw-1:0]     w_a2;
  logic [dw-1:0]     w_d2;
  logic              w_cs3, w_oe3, w_we3;
  logic [BLS_W-1:0]  w_bls3;
  logic [aw-1:0]     w_a3;
  logic [dw-1:0]     w_d3;

  logic [mem_aw-1:0] w_idx2;
  logic [mem_aw-1:0] w_idx3;

  state_t            r_state;
  state_t            w_next;
  logic              w_conflict;
  logic              w_commit;
  logic              w_rd_entry;
  logic              w_rd_step;

  logic              r_drive_en;
  logic [dw-1:0]     r_rd_data;
  logic [cnt_w-1:0]  r_wr_count;
  logic [cnt_w-1:0]  r_rd_count;
  logic              r_proto_err;

  logic [dw-1:0]     r_mem [0:(1<<mem_aw)-1];

  assign w_pins = {bus.mem_cs_n, bus.mem_oe_n, bus.mem_we_n,
                   bus.mem_bls_n, bus.mem_a, mem_d};

  async_mem_sync #(
    .W       (SW),
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk   (tb_clk),
    .rst_n (tb_rst),
    .i_d   (w_pins),
    .o_s2  (w_s2),
    .o_s3  (w_s3)
  );

  assign {w_cs2, w_oe2, w_we2, w_bls2, w_a2, w_d2} = w_s2;
  assign {w_cs3, w_oe3, w_we3, w_bls3, w_a3, w_d3} = w_s3;

  // Only the word-index bits select a location; upper bits and the byte
  // offset alias onto the same word on purpose.
  assign w_idx2 = w_a2[mem_aw+1:WORD_OFS];
  assign w_idx3 = w_a3[mem_aw+1:WORD_OFS];

  // Sampled data and lane selects are only consumed one stage later.
  logic w_unused_ok;
  assign w_unused_ok = ^{w_d2, w_bls2, w_oe3};

  assign w_conflict = !w_cs2 && !w_oe2 && !w_we2;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_cs2 && !w_conflict) begin
          if (!w_we2)      w_next = ST_WRITE;
          else if (!w_oe2) w_next = ST_READ;
        end
      end
      ST_WRITE: begin
        if (w_we2 || w_cs2 || w_conflict) w_next = ST_IDLE;
      end
      ST_READ: begin
        if (w_oe2 || w_cs2 || !w_we2) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Commit on the we_n rising edge seen at s2 while the previous cycle
  // still had cs_n low; address/data/lanes come from s3, i.e. the values
  // present before the edge, so data may change together with we_n.
  // Gating on WRITE keeps a cleared oe/we conflict from ever writing.
  assign w_commit   = (r_state == ST_WRITE) && !w_we3 && w_we2 && !w_cs3;
  assign w_rd_entry = (r_state == ST_IDLE) && (w_next == ST_READ);
  assign w_rd_step  = (r_state == ST_READ) && (w_a2 != w_a3);

  // Data register and output enable follow the next state so the bus is
  // driven one cycle sooner on entry and released one cycle sooner on exit.
  always_ff @(posedge tb_clk or negedge tb_rst) begin
    if (!tb_rst) begin
      r_state     <= ST_IDLE;
      r_drive_en  <= 1'b0;
      r_rd_data   <= '0;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_drive_en <= (w_next == ST_READ);
      if (w_next == ST_READ)
        r_rd_data <= r_mem[w_idx2];
      if (w_commit)
        r_wr_count <= r_wr_count + cnt_w'(1);
      if (w_rd_entry || w_rd_step)
        r_rd_count <= r_rd_count + cnt_w'(1);
      if (w_conflict)
        r_proto_err <= 1'b1;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge tb_clk) begin
    if (w_commit) begin
      for (int i = 0; i < BLS_W; i++) begin
        if (!w_bls3[i])
          r_mem[w_idx3][8*i +: 8] <= w_d3[8*i +: 8];
      end
    end
  end

  assign mem_d     = r_drive_en ? r_rd_data : {dw{1'bz}};
  assign wr_count  = r_wr_count;
  assign rd_count  = r_rd_count;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_async_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_async_mem_slave
// Drives the asynchronous bus as an initiator, predicts every read value,
// counter value and release of mem_d from a word-array model, and checks
// the DUT through a queue drained by an independent monitor process.
// Undriven mem_d is pulled up, so high-Z reads back as all ones.
// ---------------------------------------------------------------------------
module tb_async_mem_slave;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAW = 8;
  localparam int CW  = 16;

  localparam int M_SEQ  = 0;  // we_n rises, cs_n one cycle later
  localparam int M_TOG  = 1;  // we_n and cs_n rise together, data garbled
  localparam int M_KEEP = 2;  // we_n rises, cs_n stays low

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  async_mem_slave_if #(.aw(AW)) bus ();

  wire  [DW-1:0] mem_d;
  logic          tb_den = 1'b0;
  logic [DW-1:0] tb_d   = '0;
  assign mem_d = tb_den ? tb_d : {DW{1'bz}};

  for (genvar gi = 0; gi < DW; gi++) begin : g_pu
    pullup (mem_d[gi]);
  end

  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;
  logic          proto_err;

  async_mem_slave #(
    .dw(DW), .aw(AW), .mem_aw(MAW), .cnt_w(CW)
  ) dut (
    .tb_clk    (clk),
    .tb_rst    (rst_n),
    .bus       (bus.slave),
    .mem_d     (mem_d),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .proto_err (proto_err)
  );

  // ---------------- scoreboard ----------------
  typedef enum {K_DATA, K_WRC, K_RDC, K_PERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain word array plus counters.
  logic [31:0] mdl   [256];
  bit          known [256];
  int          wr_m   = 0;
  int          rd_m   = 0;
  bit          perr_m = 1'b0;

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'hFF);
  endfunction

  task automatic push(input kind_t k, input logic [31:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = nm;
    exp_q.push_back(c);
  endtask

  task automatic push_status(input string tag);
    push(K_WRC,  32'(wr_m & 'hFFFF), {tag, "_wr_count"});
    push(K_RDC,  32'(rd_m & 'hFFFF), {tag, "_rd_count"});
    push(K_PERR, {31'b0, perr_m},    {tag, "_proto_err"});
  endtask

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      case (c.kind)
        K_DATA:  act = mem_d;
        K_WRC:   act = {16'h0, wr_count};
        K_RDC:   act = {16'h0, rd_count};
        default: act = {31'h0, proto_err};
      endcase
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] bls);
    int k = widx(addr);
    for (int i = 0; i < 4; i++)
      if (!bls[i]) mdl[k][8*i +: 8] = data[8*i +: 8];
    if (bls == 4'b0000) known[k] = 1'b1;
    wr_m++;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] bls, input int hold, input int mode);
    @(posedge clk); #1;
    bus.mem_cs_n  = 1'b0;
    bus.mem_a     = addr;
    bus.mem_bls_n = bls;
    tb_d          = data;
    tb_den        = 1'b1;
    bus.mem_we_n  = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    bus.mem_we_n = 1'b1;
    if (mode == M_TOG) begin
      bus.mem_cs_n = 1'b1;
      tb_d         = $urandom();
    end
    @(posedge clk); #1;
    if (mode == M_SEQ) bus.mem_cs_n = 1'b1;
    tb_den = 1'b0;
    repeat (4) @(posedge clk);
    model_write(addr, data, bls);
  endtask

  // cs_n rises while we_n is still low: must not write.
  task automatic do_write_abort(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.mem_cs_n  = 1'b0;
    bus.mem_a     = addr;
    bus.mem_bls_n = 4'b0000;
    tb_d          = data;
    tb_den        = 1'b1;
    bus.mem_we_n  = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.mem_cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.mem_we_n = 1'b1;
    tb_den       = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic read_begin(input logic [31:0] addr, input logic [31:0] exp,
                            input string nm);
    @(posedge clk); #1;
    bus.mem_cs_n  = 1'b0;
    bus.mem_a     = addr;
    bus.mem_bls_n = 4'b1111;  // lane selects must not mask read data
    bus.mem_oe_n  = 1'b0;
    repeat (4) @(posedge clk);
    #1 push(K_DATA, exp, nm);
    rd_m++;
  endtask

  task automatic read_move(input logic [31:0] addr, input logic [31:0] exp,
                           input string nm);
    @(posedge clk); #1;
    bus.mem_a = addr;
    repeat (4) @(posedge clk);
    #1 push(K_DATA, exp, nm);
    rd_m++;
  endtask

  task automatic read_end(input string nm);
    @(posedge clk); #1;
    bus.mem_oe_n = 1'b1;
    bus.mem_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 push(K_DATA, HIZ, nm);
    @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr, data, r;
    logic [3:0]  bls;
    int          k;

    bus.mem_cs_n  = 1'b1;
    bus.mem_oe_n  = 1'b1;
    bus.mem_we_n  = 1'b1;
    bus.mem_bls_n = 4'b0000;
    bus.mem_a     = '0;
    for (int i = 0; i < 256; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push(K_DATA, HIZ, "reset_hiz");
    push_status("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full-word write then read
    do_write(32'h10, 32'hDEADBEEF, 4'b0000, 15, M_SEQ);
    read_begin(32'h10, 32'hDEADBEEF, "t1_read");
    repeat (6) @(posedge clk);
    read_end("t1_release");
    push(K_WRC, 32'd1, "t1_wr_count");
    push(K_RDC, 32'd1, "t1_rd_count");

    // Byte-lane merge
    do_write(32'h20, 32'h11223344, 4'b0000, 8, M_SEQ);
    do_write(32'h20, 32'hAABBCCDD, 4'b1010, 8, M_SEQ);
    read_begin(32'h20, 32'h11BB33DD, "t2_lanes");
    read_end("t2_release");

    // Three writes in one cs_n window, then address-stepped read
    do_write(32'h40, 32'h1, 4'b0000, 6, M_KEEP);
    do_write(32'h44, 32'h2, 4'b0000, 6, M_KEEP);
    do_write(32'h48, 32'h3, 4'b0000, 6, M_SEQ);
    read_begin(32'h40, 32'h1, "t3_rd0");
    repeat (21) @(posedge clk);
    read_move(32'h44, 32'h2, "t3_rd1");
    repeat (21) @(posedge clk);
    read_move(32'h48, 32'h3, "t3_rd2");
    repeat (21) @(posedge clk);
    read_end("t3_release");
    push(K_WRC, 32'd6, "t3_wr_count");
    push(K_RDC, 32'd5, "t3_rd_count");

    // cs_n/we_n rise together with garbage data; then an aborted write
    do_write(32'h80, 32'h5A5A0F0F, 4'b0000, 8, M_TOG);
    do_write_abort(32'h80, 32'h12345678);
    read_begin(32'h80, 32'h5A5A0F0F, "t4_pre_edge_data");
    read_end("t4_release");
    push(K_WRC, 32'd7, "t4_wr_count");

    // oe_n and we_n low together
    @(posedge clk); #1;
    bus.mem_cs_n  = 1'b0;
    bus.mem_a     = 32'h10;
    bus.mem_bls_n = 4'b0000;
    bus.mem_oe_n  = 1'b0;
    bus.mem_we_n  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    perr_m = 1'b1;
    push(K_DATA, HIZ, "t5_conflict_hiz");
    push(K_PERR, 32'd1, "t5_proto_err");
    @(posedge clk); #1;
    bus.mem_oe_n = 1'b1;
    bus.mem_we_n = 1'b1;
    bus.mem_cs_n = 1'b1;
    repeat (4) @(posedge clk);
    read_begin(32'h10, 32'hDEADBEEF, "t5_mem_unchanged");
    read_end("t5_release");
    push_status("t5");

    // Randomized traffic against the model (aliased upper/low address bits)
    for (int n = 0; n < 40; n++) begin
      k    = $urandom_range(64, 79);
      r    = $urandom();
      addr = (r & 32'hFFFF_FC00) | (32'(k) << 2) | ($urandom() & 32'h3);
      if ($urandom_range(0, 2) == 0 && known[k]) begin
        read_begin(addr, mdl[k], "rand_read");
        repeat ($urandom_range(0, 5)) @(posedge clk);
        read_end("rand_release");
      end else begin
        data = $urandom();
        bls  = known[k] ? 4'($urandom_range(0, 15)) : 4'b0000;
        do_write(addr, data, bls, $urandom_range(6, 12),
                 ($urandom_range(0, 1) == 0) ? M_SEQ : M_TOG);
      end
    end
    push_status("rand");

    // Reset in the middle of a read
    read_begin(32'h10, 32'hDEADBEEF, "t6_before_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.mem_oe_n = 1'b1;
    bus.mem_cs_n = 1'b1;
    wr_m   = 0;
    rd_m   = 0;
    perr_m = 1'b0;
    push(K_DATA, HIZ, "t6_reset_hiz");
    push_status("t6_in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    read_begin(32'h10, 32'hDEADBEEF, "t6_after_reset");
    read_end("t6_release");
    read_begin(32'h20, 32'h11BB33DD, "t6_after_reset2");
    read_end("t6_release2");
    push_status("t6_final");

    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (wr_count !== CW'(wr_m)) begin
      n_fail++;
      $display("FAIL final_wr_count: got %0d expected %0d", wr_count, wr_m);
    end
    n_chk++;
    if (rd_count !== CW'(rd_m)) begin
      n_fail++;
      $display("FAIL final_rd_count: got %0d expected %0d", rd_count, rd_m);
    end
    n_chk++;
    if (proto_err !== perr_m) begin
      n_fail++;
      $display("FAIL final_proto_err: got %0b expected %0b", proto_err, perr_m);
    end
    n_chk++;
    if (mem_d !== HIZ) begin
      n_fail++;
      $display("FAIL final_hiz: got %08h expected %08h", mem_d, HIZ);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
